// File: rtl/i2c_eeprom_ctrl.sv
// rtl/i2c_eeprom_ctrl.sv - byte-level I2C EEPROM transaction sequencer with NACK retry
module i2c_eeprom_ctrl #(
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter int         MAX_RETRY = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Wr_req,
  input  logic       Rd_req,
  input  logic [7:0] Addr,
  input  logic [7:0] Wr_data,
  output logic [7:0] Rd_data,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [5:0] Cmd,
  output logic       Go,
  output logic [7:0] Tx_DATA,
  input  logic [7:0] Rx_DATA,
  input  logic       Trans_Done,
  input  logic       ack_o
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_CNT = RW'(MAX_RETRY);

  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_ADDR, S_WDATA, S_RDEV, S_RDATA, S_ABORT, S_FIN
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_wait, w_wait_nxt;   // 0 = issue phase (Go), 1 = waiting for Trans_Done
  logic          r_is_rd;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic [7:0]    r_rd_data;
  logic [RW-1:0] r_retry;
  logic          r_err;
  logic          w_accept, w_retry, w_fail, w_capture, w_retry_ok, w_seg;

  assign w_retry_ok = (r_retry < MAX_CNT);
  assign Rd_data    = r_rd_data;

  // State register: FSM state and segment phase
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_wait  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Datapath registers: latched request, retry count, error flag, read data
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_is_rd   <= 1'b0;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_rd_data <= 8'h00;
      r_retry   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_rd <= ~Wr_req;
        r_addr  <= Addr;
        r_data  <= Wr_data;
        r_retry <= '0;
        r_err   <= 1'b0;
      end
      if (w_retry)   r_retry   <= r_retry + RW'(1);
      if (w_fail)    r_err     <= 1'b1;
      if (w_capture) r_rd_data <= Rx_DATA;
    end
  end

  // Next-state logic: segment sequencing, ack check and retry decision
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_accept    = 1'b0;
    w_retry     = 1'b0;
    w_fail      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait_nxt = 1'b0;
        if (Wr_req || Rd_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DEV;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = 1'b0;
      end
      default: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else if (Trans_Done) begin
          w_wait_nxt = 1'b0;
          case (r_state)
            S_DEV:   w_state_nxt = ack_o ? S_ABORT : S_ADDR;
            S_ADDR:  w_state_nxt = ack_o ? S_ABORT : (r_is_rd ? S_RDEV : S_WDATA);
            S_RDEV:  w_state_nxt = ack_o ? S_ABORT : S_RDATA;
            S_RDATA: begin
              w_capture   = 1'b1;
              w_state_nxt = S_FIN;
            end
            S_WDATA, S_ABORT: begin
              // A NACKed data byte already carried its stop, so it retries directly
              if (r_state == S_ABORT || ack_o) begin
                if (w_retry_ok) begin
                  w_retry     = 1'b1;
                  w_state_nxt = S_DEV;
                end else begin
                  w_fail      = 1'b1;
                  w_state_nxt = S_FIN;
                end
              end else begin
                w_state_nxt = S_FIN;
              end
            end
            default: w_state_nxt = r_state;
          endcase
        end
      end
    endcase
  end

  // Output logic: shifter command/data per state, Go in the issue phase
  always_comb begin
    Cmd     = 6'b000000;
    Tx_DATA = 8'h00;
    w_seg   = 1'b1;
    case (r_state)
      S_DEV: begin
        Cmd     = CMD_STA | CMD_WR;
        Tx_DATA = {DEV_ADDR, 1'b0};
      end
      S_ADDR: begin
        Cmd     = CMD_WR;
        Tx_DATA = r_addr;
      end
      S_WDATA: begin
        Cmd     = CMD_WR | CMD_STO;
        Tx_DATA = r_data;
      end
      S_RDEV: begin
        Cmd     = CMD_STA | CMD_WR;
        Tx_DATA = {DEV_ADDR, 1'b1};
      end
      S_RDATA: Cmd = CMD_RD | CMD_NACK | CMD_STO;
      S_ABORT: Cmd = CMD_STO;
      default: w_seg = 1'b0;
    endcase
    Go   = w_seg & ~r_wait;
    Busy = (r_state != S_IDLE);
    Done = (r_state == S_FIN);
    Err  = (r_state == S_FIN) & r_err;
  end

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// tb/tb_i2c_eeprom_ctrl.sv - self-checking bench for i2c_eeprom_ctrl with segment-level EEPROM model
module tb_i2c_eeprom_ctrl;

  localparam int MAX_RETRY = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Wr_req = 1'b0;
  logic       Rd_req = 1'b0;
  logic [7:0] Addr = 8'h00;
  logic [7:0] Wr_data = 8'h00;
  logic [7:0] Rd_data;
  logic       Busy, Done, Err, Go;
  logic [5:0] Cmd;
  logic [7:0] Tx_DATA;
  logic [7:0] Rx_DATA = 8'h00;
  logic       Trans_Done = 1'b0;
  logic       ack_o = 1'b0;

  i2c_eeprom_ctrl #(.DEV_ADDR(7'b1010000), .MAX_RETRY(MAX_RETRY)) dut (
    .Clk(Clk), .Rst(Rst), .Wr_req(Wr_req), .Rd_req(Rd_req), .Addr(Addr),
    .Wr_data(Wr_data), .Rd_data(Rd_data), .Busy(Busy), .Done(Done), .Err(Err),
    .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA),
    .Trans_Done(Trans_Done), .ack_o(ack_o)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_viol = 0;
  int last_td_cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (!Done && Err) err_viol++;
  end

  // Segment log as seen by the shifter
  logic [5:0] log_cmd[$];
  logic [7:0] log_tx[$];

  // EEPROM model at I2C transaction level
  logic [7:0] ee_mem[256];
  logic [7:0] sb_mem[256];
  bit         ee_present = 1'b1;
  int         ee_wr_cyc = 20;
  int         ee_busy_until = 0;
  int         ee_lat = 3;
  int         ee_idx = 0;
  bit         ee_sel = 1'b0;
  bit         ee_rw = 1'b0;
  bit         ee_pend = 1'b0;
  logic [7:0] ee_ptr = 8'h00;
  logic [7:0] ee_wbyte = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ee_seg(input logic [5:0] c, input logic [7:0] tx, output bit nk, output logic [7:0] rx);
    nk = 1'b0;
    rx = 8'h00;
    if (c[1]) begin
      ee_idx  = 0;
      ee_sel  = 1'b0;
      ee_pend = 1'b0;
    end
    if (c[0]) begin
      if (ee_idx == 0) begin
        ee_sel = ee_present && (tx[7:1] == 7'h50) && (cyc >= ee_busy_until);
        ee_rw  = tx[0];
      end else if (ee_sel && !ee_rw) begin
        if (ee_idx == 1) ee_ptr = tx;
        else begin
          ee_pend  = 1'b1;
          ee_wbyte = tx;
        end
      end
      nk = !ee_sel;
      ee_idx++;
    end
    if (c[2]) begin
      rx = ee_sel ? ee_mem[ee_ptr] : 8'hFF;
      ee_ptr = ee_ptr + 8'd1;
    end
    if (c[3]) begin
      if (ee_pend) begin
        ee_mem[ee_ptr] = ee_wbyte;
        ee_ptr = ee_ptr + 8'd1;
        ee_busy_until = cyc + ee_wr_cyc;
      end
      ee_sel  = 1'b0;
      ee_pend = 1'b0;
    end
  endtask

  // Shifter responder: answers each Go after ee_lat cycles, abandons on reset
  initial begin : responder
    bit         nk, ab;
    logic [7:0] rx;
    forever begin
      @(negedge Clk);
      while (Go && !Rst) begin
        log_cmd.push_back(Cmd);
        log_tx.push_back(Tx_DATA);
        ee_seg(Cmd, Tx_DATA, nk, rx);
        ab = 1'b0;
        for (int i = 0; i < ee_lat; i++) begin
          @(negedge Clk);
          if (Rst) ab = 1'b1;
        end
        if (ab) begin
          ee_sel  = 1'b0;
          ee_pend = 1'b0;
        end else begin
          Trans_Done  = 1'b1;
          ack_o       = nk;
          Rx_DATA     = rx;
          last_td_cyc = cyc;
          @(negedge Clk);
          Trans_Done = 1'b0;
          ack_o      = 1'b0;
          Rx_DATA    = 8'h00;
        end
      end
    end
  end

  // exp_retry: 0 = no NACK expected, 1 = at least one NACKed attempt, 2 = either
  task automatic check_segs(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                            input bit exp_err, input int exp_retry);
    int idx = 0;
    int k = 0;
    int n;
    logic [5:0] ec[4];
    logic [7:0] et[4];
    while (idx + 1 < log_cmd.size() && log_cmd[idx] == 6'h03 && log_tx[idx] == 8'hA0
           && log_cmd[idx+1] == 6'h08) begin
      k++;
      idx += 2;
    end
    if (exp_err) begin
      chk("nack_attempts", 32'(k), 32'(MAX_RETRY + 1));
      chk("segs_after_giveup", 32'(log_cmd.size() - idx), 32'd0);
    end else begin
      if (exp_retry == 0)      chk("no_retry", 32'(k), 32'd0);
      else if (exp_retry == 1) chk("retried", 32'(k >= 1 && k <= MAX_RETRY), 32'd1);
      else                     chk("retry_bound", 32'(k <= MAX_RETRY), 32'd1);
      ec[0] = 6'h03; et[0] = 8'hA0;
      ec[1] = 6'h01; et[1] = a;
      if (is_wr) begin
        ec[2] = 6'h09; et[2] = d;
        ec[3] = 6'h00; et[3] = 8'h00;
        n = 3;
      end else begin
        ec[2] = 6'h03; et[2] = 8'hA1;
        ec[3] = 6'h2C; et[3] = 8'h00;
        n = 4;
      end
      chk("seg_count", 32'(log_cmd.size() - idx), 32'(n));
      if (log_cmd.size() - idx == n) begin
        for (int j = 0; j < n; j++) begin
          chk("seg_cmd", 32'(log_cmd[idx+j]), 32'(ec[j]));
          chk("seg_tx", 32'(log_tx[idx+j]), 32'(et[j]));
        end
      end
    end
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d,
                       input int gap, input bit poke, input bit exp_err, input int exp_retry,
                       input logic [7:0] exp_rd);
    int  d0;
    bit  got = 1'b0;
    repeat (gap) @(negedge Clk);
    log_cmd.delete();
    log_tx.delete();
    d0 = done_cnt;
    Wr_req = wr; Rd_req = rd; Addr = a; Wr_data = d;
    @(negedge Clk);
    Wr_req = 1'b0; Rd_req = 1'b0;
    Addr = 8'($urandom); Wr_data = 8'($urandom);
    chk("busy_go_after_req", 32'({Busy, Go}), 32'd3);
    for (int i = 0; i < 3000 && !got; i++) begin
      Rd_req = poke && (i == 3);
      @(negedge Clk);
      if (Done) got = 1'b1;
    end
    Rd_req = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no Done expected Done within 3000 cycles");
      return;
    end
    chk("err", 32'(Err), 32'(exp_err));
    chk("rd_data", 32'(Rd_data), 32'(exp_rd));
    chk("done_latency", 32'(cyc), 32'(last_td_cyc + 1));
    @(negedge Clk);
    chk("busy_low", 32'(Busy), 32'd0);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    check_segs(wr, a, d, exp_err, exp_retry);
    if (wr && !exp_err) sb_mem[a] = d;
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
    int         wr_cyc;
    bit         present;
    bit         poke;
    bit         exp_err;
    int         exp_retry;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit         got;
    bit         wr, rd;
    logic [7:0] a, d, last_rd;

    tbl[0] = '{1'b1, 1'b0, 8'hB1, 8'hDA, 2,  20,  1'b1, 1'b0, 1'b0, 0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'hB1, 8'h00, 40, 20,  1'b1, 1'b0, 1'b0, 0, 8'hDA};
    tbl[2] = '{1'b1, 1'b0, 8'h10, 8'h5A, 40, 20,  1'b1, 1'b0, 1'b0, 0, 8'hDA};
    tbl[3] = '{1'b0, 1'b1, 8'h10, 8'h00, 0,  20,  1'b1, 1'b0, 1'b0, 1, 8'h5A};
    tbl[4] = '{1'b0, 1'b1, 8'h10, 8'h00, 40, 20,  1'b0, 1'b0, 1'b1, 0, 8'h5A};
    tbl[5] = '{1'b1, 1'b1, 8'h20, 8'hC3, 40, 20,  1'b1, 1'b1, 1'b0, 0, 8'h5A};
    tbl[6] = '{1'b0, 1'b1, 8'h20, 8'h00, 40, 20,  1'b1, 1'b0, 1'b0, 0, 8'hC3};
    tbl[7] = '{1'b1, 1'b0, 8'h30, 8'h77, 40, 300, 1'b1, 1'b0, 1'b0, 0, 8'hC3};
    tbl[8] = '{1'b0, 1'b1, 8'h30, 8'h00, 0,  300, 1'b1, 1'b0, 1'b1, 0, 8'hC3};

    for (int i = 0; i < 256; i++) begin
      ee_mem[i] = 8'(i) ^ 8'hFF;
      sb_mem[i] = 8'(255 - i);
    end

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_cmd", 32'(Cmd), 32'd0);
    chk("rst_go", 32'(Go), 32'd0);
    chk("rst_tx", 32'(Tx_DATA), 32'd0);
    chk("rst_rd_data", 32'(Rd_data), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    Rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      ee_present = tbl[i].present;
      ee_wr_cyc  = tbl[i].wr_cyc;
      do_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].gap, tbl[i].poke,
            tbl[i].exp_err, tbl[i].exp_retry, tbl[i].exp_rd);
    end
    ee_present = 1'b1;

    // Reset during the ADDR wait phase
    repeat (320) @(negedge Clk);
    ee_wr_cyc = 20;
    Wr_req = 1'b1; Addr = 8'h44; Wr_data = 8'h99;
    @(negedge Clk);
    Wr_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (Go && Cmd == 6'h01) got = 1'b1;
      else @(negedge Clk);
    end
    chk("reach_addr_issue", 32'(got), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("midrst_go", 32'(Go), 32'd0);
    chk("midrst_cmd", 32'(Cmd), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_rd_data", 32'(Rd_data), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    do_op(1'b1, 1'b0, 8'h44, 8'h99, 10, 1'b0, 1'b0, 0, 8'h00);
    do_op(1'b0, 1'b1, 8'h44, 8'h00, 40, 1'b0, 1'b0, 0, 8'h99);
    last_rd = 8'h99;

    // Randomized traffic against the scoreboard
    ee_wr_cyc = 6;
    for (int n = 0; n < 40; n++) begin
      ee_lat = int'($urandom_range(1, 4));
      wr = 1'($urandom_range(0, 1));
      rd = !wr;
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      if (rd) last_rd = sb_mem[a];
      do_op(wr, rd, a, d, int'($urandom_range(0, 5)), 1'b0, 1'b0, 2, last_rd);
    end

    chk("err_only_with_done", 32'(err_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_ctrl.md
# i2c_eeprom_ctrl

Byte-level transaction sequencer for the I2C bit shifter. It accepts single-byte random write and random read requests from system logic. Each request is expanded into the shifter's command segments (start/write/read/stop/nack), and the block handshakes each segment with `Go`/`Trans_Done`. It checks slave acknowledge, retries NACKed transactions (EEPROM write-cycle polling), and returns read data plus completion status. It sits directly between the bus-master logic and `i2c_bit_shifter`.

## Interface
Parameters:
- `DEV_ADDR`, 7'b1010000, 7-bit slave address.
- `MAX_RETRY`, 3, restarts allowed after a slave NACK (0 = no retry).

Ports:
- `Clk`  in  1  system clock; all logic on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Wr_req`  in  1  single-cycle write request (sampled only when `Busy`=0).
- `Rd_req`  in  1  single-cycle read request (sampled only when `Busy`=0).
- `Addr`  in  8  word address, latched on acceptance.
- `Wr_data`  in  8  write byte, latched on acceptance.
- `Rd_data`  out  8  last byte read; holds until the next successful read.
- `Busy`  out  1  transaction in progress.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  valid with `Done`; 1 = retries exhausted on NACK.
- `Cmd`  out  6  shifter command, one-hot OR: WR=000001, STA=000010, RD=000100, STO=001000, ACK=010000, NACK=100000.
- `Go`  out  1  one-cycle segment start pulse to shifter.
- `Tx_DATA`  out  8  shifter transmit byte.
- `Rx_DATA`  in  8  shifter receive byte.
- `Trans_Done`  in  1  shifter segment-complete pulse.
- `ack_o`  in  1  slave ack of the last WR segment, valid with `Trans_Done`; 0 = ACK.

## Operation
- States: IDLE, DEV, ADDR, WDATA, RDEV, RDATA, ABORT, FIN.
- Every state except IDLE and FIN has two phases:
  - Issue: drive `Cmd`/`Tx_DATA`, pulse `Go` for one cycle.
  - Wait: hold `Cmd`/`Tx_DATA` until `Trans_Done`.
- Acceptance in IDLE: `Wr_req` has priority over `Rd_req` when both are high. Latch `Addr`, `Wr_data` and the op type; clear the retry counter; go to DEV.
- DEV: `Cmd`=STA|WR, `Tx_DATA`={DEV_ADDR,1'b0}.
- ADDR: `Cmd`=WR, `Tx_DATA`=latched address.
- WDATA (write only): `Cmd`=WR|STO, `Tx_DATA`=latched data, then FIN.
- RDEV (read only): `Cmd`=STA|WR, `Tx_DATA`={DEV_ADDR,1'b1}.
- RDATA: `Cmd`=RD|NACK|STO (101100), `Tx_DATA`=don't-care (drive 0). On `Trans_Done`, `Rd_data`<=`Rx_DATA`, then FIN.
- ACK check: at `Trans_Done` of DEV, ADDR, WDATA or RDEV, `ack_o`=1 sends the FSM to ABORT.
  - ABORT on WDATA: the stop has already been issued, so skip the stop segment and evaluate retry directly.
  - ABORT otherwise: issue `Cmd`=STO. On `Trans_Done`, evaluate retry.
  - Retry evaluation: if retry count < MAX_RETRY, increment and return to DEV (full restart). Else go to FIN with error flagged.
- FIN: `Done`=1 for one cycle, `Err` = error flag; return to IDLE.
- Requests arriving while `Busy`=1 are ignored (not queued).
- Retry counter width: enough for MAX_RETRY; it never wraps.

## Timing
- Reset values: `Cmd`=0, `Go`=0, `Tx_DATA`=0, `Rd_data`=0, `Busy`=0, `Done`=0, `Err`=0, state IDLE.
- Reset mid-operation: all outputs return to reset values in the following cycle, with no stop segment issued.
- Request sampled at edge N; `Busy`=1 and first `Go`=1 in cycle N+1.
- `Trans_Done` seen at edge M; next segment's `Go` in cycle M+1. `Cmd`/`Tx_DATA` change in the same cycle as that `Go`.
- Final `Trans_Done` at edge M; `Done` in cycle M+1 with `Busy` still 1. `Busy`=0 in cycle M+2, and a new request is accepted at that edge.
- `Err` is 0 whenever `Done`=0.
- A `Trans_Done` arriving while in IDLE or FIN is ignored.

## Test plan
- Write 0xDA to 0xB1 with EEPROM model → segments (000011,A0), (000001,B1), (001001,DA); one `Done` pulse, `Err`=0, `Busy` low two cycles after the last `Trans_Done`.
- Read 0xB1 after the write-cycle delay → (000011,A0), (000001,B1), (000011,A1), (101100,--); `Rd_data`=0xDA, `Err`=0.
- Read issued immediately after a write, while the EEPROM is busy → NACK on DEV, STO segment, restart. Succeeds within MAX_RETRY or ends with `Done`+`Err`=1 after exactly 1+MAX_RETRY DEV attempts.
- `DEV_ADDR`=7'h51 with no device present → 4 DEV attempts, each followed by STO; `Done`=1, `Err`=1, `Rd_data` unchanged.
- `Wr_req` and `Rd_req` in the same cycle → write sequence runs. A `Rd_req` pulsed while `Busy` is ignored (no extra `Done`).
- Assert `Rst` during the ADDR wait → the next cycle shows `Go`=0, `Cmd`=0, `Busy`=0. A subsequent write completes normally.
